// File: rtl/rv_operand_fetch.sv
// Operand fetch stage: holds one decoded instruction, reads its sources from a
// registered-read register file and forwards in-flight writebacks into the operands.
module rv_operand_fetch (
  input  logic        clk,
  input  logic        rstn,

  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [4:0]  in_rs1_i,
  input  logic [4:0]  in_rs2_i,
  input  logic [4:0]  in_rd_i,
  input  logic [63:0] in_pc_i,

  output logic [4:0]  rf_rd_reg1_o,
  output logic [4:0]  rf_rd_reg2_o,
  input  logic [63:0] rf_rd_data1_i,
  input  logic [63:0] rf_rd_data2_i,

  input  logic [4:0]  wb_reg_i,
  input  logic [63:0] wb_data_i,
  input  logic        wb_en_i,

  input  logic        flush_i,

  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_rs1_data_o,
  output logic [63:0] out_rs2_data_o,
  output logic [4:0]  out_rd_o,
  output logic [63:0] out_pc_o
);

  logic        out_valid;
  logic        accept;
  logic [4:0]  hold_rs1;
  logic [4:0]  hold_rs2;
  logic [4:0]  hold_rd;
  logic [63:0] hold_pc;

  logic        d_en;
  logic [4:0]  d_reg;
  logic [63:0] d_data;

  logic        wb_hit1;
  logic        wb_hit2;
  logic        d_hit1;
  logic        d_hit2;

  assign in_ready_o = !flush_i && (!out_valid || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // The RF read is registered, so the address for the next cycle's data must
  // already point at the incoming instruction on the accepting cycle.
  assign rf_rd_reg1_o = accept ? in_rs1_i : hold_rs1;
  assign rf_rd_reg2_o = accept ? in_rs2_i : hold_rs2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      hold_rs1  <= 5'd0;
      hold_rs2  <= 5'd0;
      hold_rd   <= 5'd0;
      hold_pc   <= 64'd0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      hold_rs1  <= in_rs1_i;
      hold_rs2  <= in_rs2_i;
      hold_rd   <= in_rd_i;
      hold_pc   <= in_pc_i;
    end else if (out_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  // A write landing on the same edge as the RF read returns the old value;
  // this one-cycle copy of the writeback bus patches that window.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      d_en   <= 1'b0;
      d_reg  <= 5'd0;
      d_data <= 64'd0;
    end else begin
      d_en   <= wb_en_i;
      d_reg  <= wb_reg_i;
      d_data <= wb_data_i;
    end
  end

  assign wb_hit1 = wb_en_i && (|wb_reg_i) && (wb_reg_i == hold_rs1);
  assign wb_hit2 = wb_en_i && (|wb_reg_i) && (wb_reg_i == hold_rs2);
  assign d_hit1  = d_en && (|d_reg) && (d_reg == hold_rs1);
  assign d_hit2  = d_en && (|d_reg) && (d_reg == hold_rs2);

  always_comb begin
    out_rs1_data_o = rf_rd_data1_i;
    if (hold_rs1 == 5'd0) begin
      out_rs1_data_o = 64'd0;
    end else if (wb_hit1) begin
      out_rs1_data_o = wb_data_i;
    end else if (d_hit1) begin
      out_rs1_data_o = d_data;
    end
  end

  always_comb begin
    out_rs2_data_o = rf_rd_data2_i;
    if (hold_rs2 == 5'd0) begin
      out_rs2_data_o = 64'd0;
    end else if (wb_hit2) begin
      out_rs2_data_o = wb_data_i;
    end else if (d_hit2) begin
      out_rs2_data_o = d_data;
    end
  end

  assign out_valid_o = out_valid;
  assign out_rd_o    = hold_rd;
  assign out_pc_o    = hold_pc;

endmodule
